alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit combinational ALU (opcodes 000 ADD, 001 SUB, 010 SLL by b[2:0], 011 SRL by b[2:0], 100 AND, 101 OR, 110 XOR, 111 EQL).
- Buffers commands in a small FIFO and drives registered a/b/opcode into the ALU.
- Captures the ALU result one cycle after issue and presents it on a valid/ready result port with a zero flag.
- Decouples the bursty command source from the single-cycle ALU and a possibly stalling consumer.

Parameters:
- DEPTH, 4, command FIFO depth; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; high iff count < DEPTH.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- cmd_op  in  3  ALU opcode.
- cmd_chain  in  1  use previous result as operand a; only meaningful with ALU_CHAIN_EN.
- alu_a  out  8  registered operand a to ALU.
- alu_b  out  8  registered operand b to ALU.
- alu_opcode  out  3  registered opcode to ALU.
- alu_out  in  8  combinational ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured result.
- res_op  out  3  opcode that produced res_data.
- res_zero  out  1  res_data == 0, registered with capture.
- fifo_count  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async, takes effect immediately):
  - FIFO flushed (count 0, pointers 0); FSM to IDLE.
  - alu_a, alu_b, alu_opcode, res_data, res_op = 0; res_zero, res_valid = 0.
  - cmd_ready = 1 once rst deasserts.
  - Any in-flight or unconsumed result is discarded.
- FIFO:
  - Push on cmd_valid && cmd_ready; pop is internal (FSM issue).
  - cmd_ready depends only on count; when full, cmd_ready is low even in a cycle where a pop occurs (no full-bypass).
  - Simultaneous push and pop when not full: count unchanged; both pointers advance and wrap modulo DEPTH.
  - Pop of an empty FIFO never occurs; the FSM only pops when count != 0.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if count != 0, pop head into alu_a/alu_b/alu_opcode and go to EXEC; otherwise stay.
  - EXEC (one cycle, ALU settles): on the edge leaving EXEC, res_data <= alu_out, res_op <= alu_opcode, res_zero <= (alu_out == 0), res_valid <= 1; go to HOLD.
  - HOLD: res_valid held high with res_data/res_op/res_zero stable until res_ready.
    - On res_ready, res_valid <= 0.
    - Same edge: if count != 0, pop the next command and go to EXEC; else go to IDLE.
- Latency:
  - Command pushed into an empty idle block on edge T: popped on T+1, result valid after edge T+2.
  - Sustained throughput with res_ready tied high: one result per 2 cycles.
- alu_* outputs hold the last issued command between issues; they never change during EXEC or HOLD.
- The FIFO continues accepting commands while in HOLD, up to DEPTH entries.

Optional Feature:
- Macro: ALU_CHAIN_EN.
- Defined:
  - cmd_chain is stored in the FIFO with each entry.
  - On pop with chain = 1, alu_a <= the current res_data register (last captured result, even if already consumed) instead of the stored cmd_a.
  - A chained command issued directly from HOLD uses the result being handed off on that edge.
  - After reset, a chained first command uses 0.
- Undefined: cmd_chain is ignored and not stored; alu_a always comes from cmd_a.

Test Plan:
- Reset then push {a=8'h05, b=8'h03, op=000}, res_ready=1 -> res_valid high exactly 2 cycles after push edge; res_data=8'h08, res_zero=0, res_op=000.
- Push {8'h03, 8'h05, 001} then {8'h5A, 8'h5A, 111} back-to-back with res_ready=1 -> results 8'hFE then 8'h01, in order, 2 cycles apart.
- Hold res_ready=0 and push 5 commands (DEPTH=4) -> cmd_ready low after 4 buffered plus 1 issued; fifo_count=4. Release res_ready -> all 5 results in push order, none lost or duplicated; count returns to 0.
- XOR {8'hAA, 8'hAA, 110} -> res_data=8'h00, res_zero=1. SLL {8'h81, 8'h0B, 010} -> res_data=8'h08 (shift by 3).
- Assert rst while in HOLD with 2 commands queued -> res_valid=0 and fifo_count=0 immediately; no stale result after release.
- ALU_CHAIN_EN defined: push {8'h10, 8'h01, 000} then {chain=1, a=8'hFF, b=8'h02, op=000} -> results 8'h11 then 8'h13. Macro undefined: same stimulus -> 8'h11 then 8'h01.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an 8-bit combinational ALU: command FIFO, registered operands, result hold.
// Define ALU_CHAIN_EN to let a command take operand a from the last captured result.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_chain,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_op,
  output logic             res_zero,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef ALU_CHAIN_EN
  localparam int ENT_W = 20;
`else
  localparam int ENT_W = 19;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t           state;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] entry_in;
  logic [ENT_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [7:0]       issue_a;

`ifdef ALU_CHAIN_EN
  assign entry_in = {cmd_chain, cmd_op, cmd_b, cmd_a};
`else
  logic chain_unused;
  assign chain_unused = cmd_chain;
  assign entry_in     = {cmd_op, cmd_b, cmd_a};
`endif

  assign cmd_ready  = (count < CNT_W'(DEPTH));
  assign fifo_count = count;
  assign push       = cmd_valid && cmd_ready;
  // Pop only when the ALU is free: idle, or handing the held result off this edge.
  assign pop        = (count != '0) && ((state == IDLE) || ((state == HOLD) && res_ready));
  assign head       = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    issue_a = head[7:0];
`ifdef ALU_CHAIN_EN
    if (head[19]) issue_a = res_data;
`endif
  end

  // NOTE: the storage array has no reset; count and pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_op     <= '0;
      res_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) state <= EXEC;
        EXEC: begin
          res_data  <= alu_out;
          res_op    <= alu_opcode;
          res_zero  <= (alu_out == 8'h00);
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= pop ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        alu_a      <= issue_a;
        alu_b      <= head[15:8];
        alu_opcode <= head[18:16];
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic       res_zero;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_zero(res_zero),
    .fifo_count(fifo_count)
  );

  always_comb begin
    alu_out = 8'h00;
    case (alu_opcode)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a << alu_b[2:0];
      3'b011: alu_out = alu_a >> alu_b[2:0];
      3'b100: alu_out = alu_a & alu_b;
      3'b101: alu_out = alu_a | alu_b;
      3'b110: alu_out = alu_a ^ alu_b;
      default: alu_out = {7'b0, alu_a == alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic chain);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_chain = chain;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    if (!res_valid) check({tag, "_timeout"}, 32'(res_valid), 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_chain = 1'b0; res_ready = 1'b1;
    tick();
    tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single ADD: valid exactly two edges after the push edge.
    set_cmd(8'h05, 8'h03, 3'b000, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("add_valid_t0", 32'(res_valid), 32'd0);
    tick();
    check("add_valid_t1", 32'(res_valid), 32'd0);
    check("add_alu_a", 32'(alu_a), 32'h05);
    check("add_alu_b", 32'(alu_b), 32'h03);
    check("add_count_t1", 32'(fifo_count), 32'd0);
    tick();
    check("add_valid_t2", 32'(res_valid), 32'd1);
    check("add_data", 32'(res_data), 32'h08);
    check("add_zero", 32'(res_zero), 32'd0);
    check("add_op", 32'(res_op), 32'd0);
    tick();
    check("add_consumed", 32'(res_valid), 32'd0);

    // SUB then EQL back to back: results two cycles apart.
    set_cmd(8'h03, 8'h05, 3'b001, 1'b0);
    tick();
    set_cmd(8'h5A, 8'h5A, 3'b111, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("b2b_valid_t1", 32'(res_valid), 32'd0);
    tick();
    check("sub_valid", 32'(res_valid), 32'd1);
    check("sub_data", 32'(res_data), 32'hFE);
    check("sub_op", 32'(res_op), 32'd1);
    tick();
    check("b2b_gap", 32'(res_valid), 32'd0);
    tick();
    check("eql_valid", 32'(res_valid), 32'd1);
    check("eql_data", 32'(res_data), 32'h01);
    check("eql_op", 32'(res_op), 32'd7);
    tick();

    // XOR to zero, then SLL by b[2:0].
    set_cmd(8'hAA, 8'hAA, 3'b110, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("xor_data", 32'(res_data), 32'h00);
    check("xor_zero", 32'(res_zero), 32'd1);
    check("xor_op", 32'(res_op), 32'd6);
    tick();
    set_cmd(8'h81, 8'h0B, 3'b010, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("sll_data", 32'(res_data), 32'h08);
    check("sll_zero", 32'(res_zero), 32'd0);
    tick();

    // Stalled consumer: five pushes fill the FIFO behind one held result.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", 32'(cmd_ready), 32'd1);
      set_cmd(8'(i + 1), 8'h10, 3'b000, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_held_valid", 32'(res_valid), 32'd1);
    check("full_held_data", 32'(res_data), 32'h11);
    set_cmd(8'hEE, 8'hEE, 3'b000, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("full_no_push", 32'(fifo_count), 32'd4);
    check("full_alu_a_stable", 32'(alu_a), 32'h01);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_res("drain");
      check("drain_data", 32'(res_data), 32'(8'h11 + k));
      tick();
    end
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_valid", 32'(res_valid), 32'd0);

    // Reset while holding a result with two commands queued.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(8'h20, 8'(i), 3'b101, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    check("hold_valid", 32'(res_valid), 32'd1);
    check("hold_count", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_data", 32'(res_data), 32'd0);
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", 32'(res_valid), 32'd0);
      check("post_rst_count", 32'(fifo_count), 32'd0);
    end

    // Chained command issued straight from HOLD.
    set_cmd(8'h10, 8'h01, 3'b000, 1'b0);
    tick();
    set_cmd(8'hFF, 8'h02, 3'b000, 1'b1);
    tick();
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    tick();
    check("chain_first", 32'(res_data), 32'h11);
    tick();
    tick();
    check("chain_second_valid", 32'(res_valid), 32'd1);
`ifdef ALU_CHAIN_EN
    check("chain_second", 32'(res_data), 32'h13);
`else
    check("chain_second", 32'(res_data), 32'h01);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
